// File: rtl/store_merge_unit_pkg.sv
// Shared CPU definitions for the store path: size-select codes (common with the
// load modifier), store FSM state encodings and byte-enable patterns.
package store_merge_unit_pkg;

   localparam logic [2:0] SEL_BYTE = 3'b010;
   localparam logic [2:0] SEL_HALF = 3'b001;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam logic [3:0] BE_NONE    = 4'b0000;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   // Bytes can go anywhere; halves need an even address, and words need a multiple-of-four address.
   function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
      if (sel == SEL_BYTE)
         return 1'b0;
      else if (sel == SEL_HALF)
         return addr_lo[0];
      else
         return (addr_lo != 2'b00);
   endfunction

   function automatic logic is_sub_word(input logic [2:0] sel);
      return (sel == SEL_BYTE) || (sel == SEL_HALF);
   endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the store data into its little-endian lane of a
// word. With STORE_BE_EN defined it also emits the matching byte enables.
module store_lane_merge
   import store_merge_unit_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] data,
   input  logic [2:0]  sel,
   input  logic [1:0]  addr_lo,
   output logic [31:0] merged
`ifdef STORE_BE_EN
   ,
   output logic [3:0]  be
`endif
);

   // Any select code other than byte/half is treated as a full-word store.
   always_comb begin
      merged = old_word;
      case (sel)
         SEL_BYTE: merged[{addr_lo, 3'b000} +: 8] = data[7:0];
         SEL_HALF: begin
            if (addr_lo[1])
               merged[31:16] = data[15:0];
            else
               merged[15:0] = data[15:0];
         end
         default:  merged = data;
      endcase
   end

`ifdef STORE_BE_EN
   always_comb begin
      case (sel)
         SEL_BYTE: be = BE_BYTE0 << addr_lo;
         SEL_HALF: be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
         default:  be = BE_WORD;
      endcase
   end
`endif

endmodule

// File: rtl/store_merge_unit.sv
// MEM-stage store unit: word stores write directly, sub-word stores do read-modify-write.
// Defining STORE_BE_EN adds mem_be and replaces read-modify-write with byte-enabled writes.
module store_merge_unit
   import store_merge_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_req,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [2:0]        st_sel,
   output logic              st_ready,
   output logic              st_done,
   output logic              st_misalign,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [31:0]       mem_rdata,
   output logic              mem_wr_en,
   output logic [31:0]       mem_wdata
`ifdef STORE_BE_EN
   ,
   output logic [3:0]        mem_be
`endif
);

`ifdef STORE_BE_EN
   localparam logic USE_RMW = 1'b0;
`else
   localparam logic USE_RMW = 1'b1;
`endif

   logic [1:0]  state;
   logic [1:0]  next_state;
   logic [1:0]  addr_lo;
   logic [31:0] data_q;
   logic [2:0]  sel_q;
   logic [31:0] old_word;
   logic [31:0] merged;
   logic        unused_bits;

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (st_req) begin
               if (is_misaligned(st_sel, st_addr[1:0]))
                  next_state = ST_ERR;
               else if (is_sub_word(st_sel) && USE_RMW)
                  next_state = ST_RD;
               else
                  next_state = ST_WR;
            end
         end
         ST_RD:   next_state = ST_WR;
         default: next_state = ST_IDLE;
      endcase
   end

   // Request fields are captured only on acceptance, so mem_addr stays put until the write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mem_addr <= '0;
         addr_lo  <= 2'b00;
         data_q   <= '0;
         sel_q    <= '0;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && st_req) begin
            mem_addr <= st_addr[MEM_AW+1:2];
            addr_lo  <= st_addr[1:0];
            data_q   <= st_data;
            sel_q    <= st_sel;
         end
      end
   end

`ifdef STORE_BE_EN
   logic [3:0] lane_be;

   // Replicating the data as the base word makes the merge output the replicated lanes.
   always_comb begin
      case (sel_q)
         SEL_BYTE: old_word = {4{data_q[7:0]}};
         SEL_HALF: old_word = {2{data_q[15:0]}};
         default:  old_word = data_q;
      endcase
   end

   store_lane_merge u_merge (
      .old_word (old_word),
      .data     (data_q),
      .sel      (sel_q),
      .addr_lo  (addr_lo),
      .merged   (merged),
      .be       (lane_be)
   );

   assign mem_be      = (state == ST_WR) ? lane_be : BE_NONE;
   assign unused_bits = ^{st_addr[ADDR_W-1:MEM_AW+2], mem_rdata};
`else
   assign old_word = mem_rdata;

   store_lane_merge u_merge (
      .old_word (old_word),
      .data     (data_q),
      .sel      (sel_q),
      .addr_lo  (addr_lo),
      .merged   (merged)
   );

   assign unused_bits = ^st_addr[ADDR_W-1:MEM_AW+2];
`endif

   assign st_ready    = (state == ST_IDLE);
   assign st_done     = (state == ST_WR);
   assign st_misalign = (state == ST_ERR);
   assign mem_rd_en   = (state == ST_RD);
   assign mem_wr_en   = (state == ST_WR);
   assign mem_wdata   = (state == ST_WR) ? merged : 32'h0;

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit with a behavioural synchronous RAM.
// Works in both builds; compile with STORE_BE_EN defined to exercise the byte-enable variant.
module tb_store_merge_unit;
   import store_merge_unit_pkg::*;

`ifdef STORE_BE_EN
   localparam logic BE_MODE = 1'b1;
`else
   localparam logic BE_MODE = 1'b0;
`endif

   typedef struct packed {
      logic        is_err;
      logic [10:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_req;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_sel;
   logic        st_ready;
   logic        st_done;
   logic        st_misalign;
   logic [10:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
`ifdef STORE_BE_EN
   logic [3:0]  mem_be;
`endif

   logic [31:0] ram [0:2047];
   logic [31:0] model_mem [0:2047];
   logic        pre_we;
   logic [10:0] pre_addr;
   logic [31:0] pre_data;

   exp_t exp_q[$];
   int   total_checks = 0;
   int   bad_checks = 0;

   always #5 clk = ~clk;

   store_merge_unit #(.ADDR_W(32), .MEM_AW(11)) dut (
      .clk         (clk),
      .rst         (rst),
      .st_req      (st_req),
      .st_addr     (st_addr),
      .st_data     (st_data),
      .st_sel      (st_sel),
      .st_ready    (st_ready),
      .st_done     (st_done),
      .st_misalign (st_misalign),
      .mem_addr    (mem_addr),
      .mem_rd_en   (mem_rd_en),
      .mem_rdata   (mem_rdata),
      .mem_wr_en   (mem_wr_en),
`ifdef STORE_BE_EN
      .mem_be      (mem_be),
`endif
      .mem_wdata   (mem_wdata)
   );

   // Synchronous RAM: read data appears the cycle after mem_rd_en; pre_we lets the bench seed words.
   always @(posedge clk) begin
      if (mem_rd_en)
         mem_rdata <= ram[mem_addr];
      if (pre_we)
         ram[pre_addr] <= pre_data;
      else if (mem_wr_en) begin
`ifdef STORE_BE_EN
         for (int i = 0; i < 4; i++)
            if (mem_be[i])
               ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
`else
         ram[mem_addr] <= mem_wdata;
`endif
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_checks++;
      if (observed !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Every RAM write or misalignment pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (mem_wr_en || st_done)
         checkOutput("done_with_wr", {31'b0, st_done}, {31'b0, mem_wr_en});
      if (mem_wr_en || st_misalign) begin
         if (exp_q.size() == 0)
            checkOutput("unexpected_event", 32'd1, 32'd0);
         else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", {31'b0, st_misalign}, {31'b0, e.is_err});
            if (mem_wr_en) begin
               checkOutput("wr_addr", {21'b0, mem_addr}, {21'b0, e.addr});
               checkOutput("wr_data", mem_wdata, e.wdata);
`ifdef STORE_BE_EN
               checkOutput("wr_be", {28'b0, mem_be}, {28'b0, e.be});
`endif
            end
         end
      end
   end

   task automatic preloadWord(input logic [10:0] word, input logic [31:0] value);
      model_mem[word] = value;
      pre_addr = word;
      pre_data = value;
      pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Reference model: expected write word, lane enables and error flag for one store.
   function automatic exp_t modelStore(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel);
      exp_t        e;
      logic [31:0] repl;
      logic [31:0] old;
      logic [31:0] next_word;
      e.addr = addr[12:2];
      e.is_err = (sel == 3'b001 && addr[0]) || (sel != 3'b010 && sel != 3'b001 && addr[1:0] != 2'b00);
      if (sel == 3'b010) begin
         repl = {data[7:0], data[7:0], data[7:0], data[7:0]};
         e.be = 4'b0001 << addr[1:0];
      end else if (sel == 3'b001) begin
         repl = {data[15:0], data[15:0]};
         e.be = addr[1] ? 4'b1100 : 4'b0011;
      end else begin
         repl = data;
         e.be = 4'b1111;
      end
      old = model_mem[e.addr];
      for (int i = 0; i < 4; i++)
         next_word[8*i +: 8] = e.be[i] ? repl[8*i +: 8] : old[8*i +: 8];
`ifdef STORE_BE_EN
      e.wdata = repl;
`else
      e.wdata = next_word;
`endif
      return e;
   endfunction

   function automatic void commitModel(input exp_t e);
      for (int i = 0; i < 4; i++)
         if (e.be[i])
            model_mem[e.addr][8*i +: 8] = e.wdata[8*i +: 8];
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] sel);
      exp_t e;
      int   busy = 0;
      int   rd_seen = 0;
      int   wr_cyc = 0;
      int   err_cyc = 0;
      logic done = 1'b0;
      logic sub;
      int   exp_busy;
      checkOutput("ready_before", {31'b0, st_ready}, 32'd1);
      e = modelStore(addr, data, sel);
      sub = (sel == 3'b010) || (sel == 3'b001);
      exp_busy = e.is_err ? 1 : ((sub && !BE_MODE) ? 2 : 1);
      exp_q.push_back(e);
      if (!e.is_err)
         commitModel(e);
      st_req = 1'b1;
      st_addr = addr;
      st_data = data;
      st_sel = sel;
      @(posedge clk);
      #1;
      for (int c = 1; c <= 8; c++) begin
         st_addr = $urandom;
         st_data = $urandom;
         st_sel = 3'($urandom_range(0, 7));
         @(negedge clk);
         if (st_ready) begin
            done = 1'b1;
            break;
         end
         busy++;
         if (mem_rd_en) rd_seen++;
         if (mem_wr_en) wr_cyc = c;
         if (st_misalign) err_cyc = c;
         checkOutput("addr_stable", {21'b0, mem_addr}, {21'b0, e.addr});
      end
      st_req = 1'b0;
      checkOutput("ready_return", {31'b0, done}, 32'd1);
      checkOutput("busy_cycles", busy, exp_busy);
      checkOutput("rd_count", rd_seen, (!e.is_err && sub && !BE_MODE) ? 1 : 0);
      checkOutput("wr_cycle", wr_cyc, e.is_err ? 0 : exp_busy);
      checkOutput("err_cycle", err_cyc, e.is_err ? 1 : 0);
   endtask

   initial begin
      exp_t        e;
      logic [31:0] a;
      logic [2:0]  sels [5] = '{3'b010, 3'b001, 3'b000, 3'b111, 3'b100};
      rst = 1'b1;
      st_req = 1'b0;
      st_addr = '0;
      st_data = '0;
      st_sel = '0;
      pre_we = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", {31'b0, st_ready}, 32'd1);
      checkOutput("rst_done", {31'b0, st_done}, 32'd0);
      checkOutput("rst_misalign", {31'b0, st_misalign}, 32'd0);
      checkOutput("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
      checkOutput("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
      checkOutput("rst_mem_addr", {21'b0, mem_addr}, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(32'h0000_0100, 32'hDEAD_BEEF, 3'b000);
      preloadWord(11'h040, 32'h1122_3344);
      applyStimulus(32'h0000_0103, 32'h0000_00AA, SEL_BYTE);
      preloadWord(11'h000, 32'h1122_3344);
      applyStimulus(32'h0000_0002, 32'h0000_BEEF, SEL_HALF);
      preloadWord(11'h000, 32'h1122_3344);
      applyStimulus(32'h0000_0000, 32'h0000_BEEF, SEL_HALF);
      applyStimulus(32'h0000_0001, 32'h0000_1234, SEL_HALF);
      applyStimulus(32'h0000_0002, 32'h0000_0055, 3'b000);
      preloadWord(11'h000, 32'h0000_0000);
      applyStimulus(32'h0000_0001, 32'h0000_005A, SEL_BYTE);

      // Back-to-back stores, the last one merging into a word the first just wrote.
      applyStimulus(32'h0000_0200, 32'h0102_0304, 3'b011);
      applyStimulus(32'h0000_0204, 32'hA5A5_5A5A, 3'b111);
      applyStimulus(32'h0000_0201, 32'h0000_00EE, SEL_BYTE);
      applyStimulus(32'hFFFF_E004, 32'h0BAD_CAFE, 3'b000);

      for (int n = 0; n < 16; n++) begin
         a = $urandom;
         preloadWord(a[12:2], $urandom);
         applyStimulus(a, $urandom, sels[$urandom_range(0, 4)]);
      end

      // Reset during the cycle after acceptance must drop the read-modify-write.
      preloadWord(11'h050, 32'hCAFE_F00D);
      e = modelStore(32'h0000_0141, 32'h0000_0077, SEL_BYTE);
`ifdef STORE_BE_EN
      exp_q.push_back(e);
      commitModel(e);
`endif
      st_req = 1'b1;
      st_addr = 32'h0000_0141;
      st_data = 32'h0000_0077;
      st_sel = SEL_BYTE;
      @(posedge clk);
      #1;
      st_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checkOutput("rst_drop_wr", {31'b0, mem_wr_en}, 32'd0);
         checkOutput("rst_drop_ready", {31'b0, st_ready}, 32'd1);
      end
      applyStimulus(32'h0000_0144, 32'h7777_8888, 3'b000);
      applyStimulus(32'h0000_0142, 32'h0000_9999, SEL_HALF);

      repeat (2) @(negedge clk);
      checkOutput("queue_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load data modifier in the MEM stage of the 54-instruction pipelined CPU.
- Takes SB/SH/SW requests: register data, byte address, size select.
- Builds the correctly lane-placed memory word for a word-wide data RAM.
- Sub-word stores run a read-modify-write sequence; `st_ready` low stalls the pipeline.

Parameters:
- ADDR_W, 32, width of the byte address from the ALU.
- MEM_AW, 11, word-address width to data RAM (2048 words).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- st_req  in  1  store request from MEM stage, sampled only when st_ready=1
- st_addr  in  ADDR_W  byte address
- st_data  in  32  rt register value; low byte/half used for SB/SH
- st_sel  in  3  3'b010 SB, 3'b001 SH, any other value SW (same byte/half codes as the load path)
- st_ready  out  1  high in IDLE only; low = stall MEM stage
- st_done  out  1  one-cycle pulse on the memory write cycle
- st_misalign  out  1  one-cycle pulse when a store is rejected for misalignment
- mem_addr  out  MEM_AW  word address = latched st_addr[MEM_AW+1:2]
- mem_rd_en  out  1  synchronous RAM read strobe; data arrives next cycle
- mem_rdata  in  32  RAM read data
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  32  merged write word
- mem_be  out  4  byte enables; present only with STORE_BE_EN

Behaviour:
- Reset: state=IDLE, st_ready=1; st_done, st_misalign, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0.
- Acceptance: in IDLE, `st_req=1` latches addr, data and sel at the clock edge.
- FSM states: IDLE, RD, WR, ERR.
- IDLE transitions on an accepted request:
  - misaligned → ERR. Misaligned means SH with addr[0]=1, or SW with addr[1:0]≠0.
  - SW → WR.
  - SB/SH → RD.
- RD: mem_rd_en=1 for exactly one cycle → WR.
- WR: mem_wr_en=1 and st_done=1 for one cycle → IDLE.
  - SW: mem_wdata = latched data.
  - SB/SH: mem_wdata = mem_rdata with the target lane replaced.
- ERR: st_misalign=1 for one cycle, no RAM access → IDLE.
- Latency from accept edge:
  - SW write in cycle +1; busy 1 cycle.
  - SB/SH write in cycle +2; busy 2 cycles.
  - Error flagged in cycle +1.
- Byte lanes are little-endian:
  - SB: addr[1:0]=n replaces bits [8n+7:8n] with data[7:0].
  - SH: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with data[15:0].
- st_req while not in IDLE is ignored. The pipeline holds the request because st_ready=0.
- Back-to-back requests: a new request is accepted in the IDLE cycle following WR/ERR. There is no bypass from a pending write.
- Address bits above MEM_AW+1 are ignored; accesses wrap modulo RAM size.
- mem_addr is stable from the cycle after accept through WR.
- mem_wdata is don't-care when mem_wr_en=0, but is driven 0 in IDLE.
- rst asserted in any state returns to IDLE next edge. An in-flight write is dropped: no mem_wr_en after the reset edge.

Optional Feature:
- STORE_BE_EN defined:
  - mem_be port exists; RD state is never entered.
  - All aligned stores write in cycle +1 with replicated data: SB data[7:0] on all lanes, SH data[15:0] on both halves.
  - mem_be: SB one-hot by addr[1:0]; SH 4'b0011/4'b1100; SW 4'b1111; 0 when not writing.
- STORE_BE_EN undefined: no mem_be port; sub-word stores use read-modify-write as above.

Decomposition:
- Shared cpu package holds:
  - sel encodings SEL_BYTE=3'b010, SEL_HALF=3'b001, shared with the load modifier;
  - FSM state localparams;
  - byte-enable constants.
- One combinational sub-module, store_lane_merge: inputs old word, data, sel, addr[1:0]; output merged word (and be). Reusable by the bench reference model.

Test Plan:
- SW: addr 0x100, data 0xDEADBEEF → cycle+1 mem_wr_en=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, st_ready low one cycle.
- SB: addr 0x103, data 0x000000AA, RAM holds 0x11223344 → RD at +1, WR at +2 with mem_wdata=0xAA223344.
- SH: addr 0x002, data 0x0000BEEF, RAM holds 0x11223344 → mem_wdata=0xBEEF3344. Same at addr 0x000 → 0x1122BEEF.
- Misaligned SH at addr 0x001 and SW at 0x002 → st_misalign pulse at +1, no mem_rd_en/mem_wr_en, st_ready back high at +2.
- rst asserted in RD state of an SB → next cycle IDLE, no write ever issued. A following SW completes normally.
- With STORE_BE_EN: SB addr 0x1 data 0x5A → cycle+1 mem_be=4'b0010, mem_wdata=0x5A5A5A5A, no read.
